// File: rtl/mem_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned RW = 4;

    localparam logic [RW-1:0] DATA_REGION_DEF = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // Request payload held toward the memory controller for one transaction.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic          cs;
        logic          rd;
        logic          wr;
    } mc_req_t;

    function automatic logic in_region(input logic [AW-1:0] addr,
                                       input logic [RW-1:0] region);
        return addr[AW-1 -: RW] == region;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick (combinational) with registered last-grant history.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    ifu_req,
    input  logic    lsu_req,
    input  logic    grant_en,
    output logic    gnt_valid_c,
    output req_id_e gnt_id_c
);

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    // On a tie, the requester that did not win last time gets the port.
    always_comb begin
        gnt_valid_c = ifu_req | lsu_req;
        gnt_id_c    = REQ_IFU;
        if (ifu_req && lsu_req) begin
            gnt_id_c = (last_grant_q == REQ_IFU) ? REQ_LSU : REQ_IFU;
        end else if (lsu_req) begin
            gnt_id_c = REQ_LSU;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_en && gnt_valid_c) begin
            last_grant_d = gnt_id_c;
        end
    end

    // Reset to LSU so IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= REQ_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory-controller port between IFU and LSU: round-robin grant,
// one outstanding transaction, valid/ready/rdata_valid handshake and watchdog.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [3:0]  DATA_REGION = DATA_REGION_DEF,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned TW          = 7
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_valid_in,
    input  logic [AW-1:0] ifu_addr_in,
    output logic          ifu_ready_out,
    output logic          ifu_rdata_valid_out,
    output logic          ifu_err_out,

    input  logic          lsu_valid_in,
    input  logic [AW-1:0] lsu_addr_in,
    input  logic          lsu_write_en_in,
    input  logic [DW-1:0] lsu_write_data_in,
    input  logic [BW-1:0] lsu_write_byte_en_in,
    output logic          lsu_ready_out,
    output logic          lsu_rdata_valid_out,
    output logic          lsu_err_out,

    output logic [DW-1:0] rdata_out,

    output logic [AW-1:0] mc_addr_out,
    output logic [DW-1:0] mc_write_data_out,
    output logic [BW-1:0] mc_write_byte_en_out,
    output logic          mc_cs_out,
    output logic          mc_read_en_out,
    output logic          mc_write_en_out,
    output logic          mc_valid_out,
    input  logic          mc_ready_in,
    input  logic          mc_rdata_valid_in,
    input  logic [DW-1:0] mc_read_data_in
);

    state_e        state_q,     state_d;
    req_id_e       owner_q,     owner_d;
    logic [TW-1:0] wd_q,        wd_d;
    mc_req_t       mc_req_q,    mc_req_d;
    logic          mc_valid_q,  mc_valid_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic          ifu_rv_q,    ifu_rv_d;
    logic          lsu_rv_q,    lsu_rv_d;
    logic          ifu_err_q,   ifu_err_d;
    logic          lsu_err_q,   lsu_err_d;

    logic          pulse_busy_c;
    logic          grant_en_c;
    logic          wd_expired_c;
    logic          gnt_valid_c;
    req_id_e       gnt_id_c;

    // No new grant while a completion pulse is still visible.
    assign pulse_busy_c = ifu_rv_q | lsu_rv_q | ifu_err_q | lsu_err_q;
    assign grant_en_c   = (state_q == ST_IDLE) && !pulse_busy_c;
    assign wd_expired_c = (wd_q == TW'(TIMEOUT - 1));

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .ifu_req     (ifu_valid_in),
        .lsu_req     (lsu_valid_in),
        .grant_en    (grant_en_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wd_d       = '0;
        mc_req_d   = mc_req_q;
        mc_valid_d = mc_valid_q;
        rdata_d    = rdata_q;
        ifu_rv_d   = 1'b0;
        lsu_rv_d   = 1'b0;
        ifu_err_d  = 1'b0;
        lsu_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_en_c && gnt_valid_c) begin
                    state_d    = ST_REQ;
                    owner_d    = gnt_id_c;
                    mc_valid_d = 1'b1;
                    mc_req_d   = '0;
                    if (gnt_id_c == REQ_IFU) begin
                        mc_req_d.addr = ifu_addr_in;
                        mc_req_d.rd   = 1'b1;
                    end else begin
                        mc_req_d.addr  = lsu_addr_in;
                        mc_req_d.wdata = lsu_write_data_in;
                        mc_req_d.be    = lsu_write_byte_en_in;
                        mc_req_d.cs    = in_region(lsu_addr_in, DATA_REGION);
                        mc_req_d.rd    = !lsu_write_en_in;
                        mc_req_d.wr    = lsu_write_en_in;
                    end
                end
            end

            ST_REQ: begin
                if (mc_ready_in) begin
                    mc_valid_d  = 1'b0;
                    mc_req_d.rd = 1'b0;
                    mc_req_d.wr = 1'b0;
                    if (mc_req_q.wr) begin
                        lsu_rv_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (mc_rdata_valid_in) begin
                        // Same-cycle accept and data: complete without RESP.
                        rdata_d  = mc_read_data_in;
                        ifu_rv_d = (owner_q == REQ_IFU);
                        lsu_rv_d = (owner_q == REQ_LSU);
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (wd_expired_c) begin
                    mc_valid_d  = 1'b0;
                    mc_req_d.rd = 1'b0;
                    mc_req_d.wr = 1'b0;
                    ifu_err_d   = (owner_q == REQ_IFU);
                    lsu_err_d   = (owner_q == REQ_LSU);
                    state_d     = ST_IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end

            ST_RESP: begin
                if (mc_rdata_valid_in) begin
                    rdata_d  = mc_read_data_in;
                    ifu_rv_d = (owner_q == REQ_IFU);
                    lsu_rv_d = (owner_q == REQ_LSU);
                    state_d  = ST_IDLE;
                end else if (wd_expired_c) begin
                    ifu_err_d = (owner_q == REQ_IFU);
                    lsu_err_d = (owner_q == REQ_LSU);
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                mc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_IFU;
            wd_q       <= '0;
            mc_req_q   <= '0;
            mc_valid_q <= 1'b0;
            rdata_q    <= '0;
            ifu_rv_q   <= 1'b0;
            lsu_rv_q   <= 1'b0;
            ifu_err_q  <= 1'b0;
            lsu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wd_q       <= wd_d;
            mc_req_q   <= mc_req_d;
            mc_valid_q <= mc_valid_d;
            rdata_q    <= rdata_d;
            ifu_rv_q   <= ifu_rv_d;
            lsu_rv_q   <= lsu_rv_d;
            ifu_err_q  <= ifu_err_d;
            lsu_err_q  <= lsu_err_d;
        end
    end

    // Accept pulses follow the controller's ready directly.
    assign ifu_ready_out = (state_q == ST_REQ) && mc_ready_in && (owner_q == REQ_IFU);
    assign lsu_ready_out = (state_q == ST_REQ) && mc_ready_in && (owner_q == REQ_LSU);

    assign ifu_rdata_valid_out  = ifu_rv_q;
    assign lsu_rdata_valid_out  = lsu_rv_q;
    assign ifu_err_out          = ifu_err_q;
    assign lsu_err_out          = lsu_err_q;
    assign rdata_out            = rdata_q;
    assign mc_addr_out          = mc_req_q.addr;
    assign mc_write_data_out    = mc_req_q.wdata;
    assign mc_write_byte_en_out = mc_req_q.be;
    assign mc_cs_out            = mc_req_q.cs;
    assign mc_read_en_out       = mc_req_q.rd;
    assign mc_write_en_out      = mc_req_q.wr;
    assign mc_valid_out         = mc_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after posedge, outputs checked 2ns after.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        ifu_valid_in;
    logic [31:0] ifu_addr_in;
    logic        ifu_ready_out, ifu_rdata_valid_out, ifu_err_out;
    logic        lsu_valid_in;
    logic [31:0] lsu_addr_in;
    logic        lsu_write_en_in;
    logic [31:0] lsu_write_data_in;
    logic [3:0]  lsu_write_byte_en_in;
    logic        lsu_ready_out, lsu_rdata_valid_out, lsu_err_out;
    logic [31:0] rdata_out;
    logic [31:0] mc_addr_out, mc_write_data_out;
    logic [3:0]  mc_write_byte_en_out;
    logic        mc_cs_out, mc_read_en_out, mc_write_en_out, mc_valid_out;
    logic        mc_ready_in, mc_rdata_valid_in;
    logic [31:0] mc_read_data_in;

    int n_cmp;
    int n_bad;

    // {ifu_ready, ifu_rv, ifu_err, lsu_ready, lsu_rv, lsu_err}
    logic [5:0]   pulses;
    logic [6:0]   ctl;
    logic [109:0] all_out;
    assign pulses  = {ifu_ready_out, ifu_rdata_valid_out, ifu_err_out,
                      lsu_ready_out, lsu_rdata_valid_out, lsu_err_out};
    assign ctl     = {mc_valid_out, mc_cs_out, mc_read_en_out, mc_write_en_out, mc_write_byte_en_out[2:0]};
    assign all_out = {pulses, rdata_out, mc_addr_out, mc_write_data_out, mc_write_byte_en_out,
                      mc_cs_out, mc_read_en_out, mc_write_en_out, mc_valid_out};

    mem_arbiter #(.DATA_REGION(4'h1), .TIMEOUT(TIMEOUT), .TW(7)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ifu_valid_in         (ifu_valid_in),
        .ifu_addr_in          (ifu_addr_in),
        .ifu_ready_out        (ifu_ready_out),
        .ifu_rdata_valid_out  (ifu_rdata_valid_out),
        .ifu_err_out          (ifu_err_out),
        .lsu_valid_in         (lsu_valid_in),
        .lsu_addr_in          (lsu_addr_in),
        .lsu_write_en_in      (lsu_write_en_in),
        .lsu_write_data_in    (lsu_write_data_in),
        .lsu_write_byte_en_in (lsu_write_byte_en_in),
        .lsu_ready_out        (lsu_ready_out),
        .lsu_rdata_valid_out  (lsu_rdata_valid_out),
        .lsu_err_out          (lsu_err_out),
        .rdata_out            (rdata_out),
        .mc_addr_out          (mc_addr_out),
        .mc_write_data_out    (mc_write_data_out),
        .mc_write_byte_en_out (mc_write_byte_en_out),
        .mc_cs_out            (mc_cs_out),
        .mc_read_en_out       (mc_read_en_out),
        .mc_write_en_out      (mc_write_en_out),
        .mc_valid_out         (mc_valid_out),
        .mc_ready_in          (mc_ready_in),
        .mc_rdata_valid_in    (mc_rdata_valid_in),
        .mc_read_data_in      (mc_read_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_valid_in = 1'b0; ifu_addr_in = '0;
        lsu_valid_in = 1'b0; lsu_addr_in = '0; lsu_write_en_in = 1'b0;
        lsu_write_data_in = '0; lsu_write_byte_en_in = '0;
        mc_ready_in = 1'b0; mc_rdata_valid_in = 1'b0; mc_read_data_in = '0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_valid_in = 1'b1; ifu_addr_in = 32'h0000_0040;
        #1;
        n_cmp++;
        if (mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL ifu_idle_valid: got %b required 0", mc_valid_out);
        end
        tick();
        // first REQ cycle, controller not ready yet
        #1;
        n_cmp++;
        if (ctl !== 7'b1010000 || mc_addr_out !== 32'h40 || mc_write_data_out !== 32'h0
            || mc_write_byte_en_out !== 4'h0 || pulses !== 6'b0) begin
            n_bad++;
            $display("FAIL ifu_req_fields: got ctl=%b addr=%h wd=%h be=%h pulses=%b required ctl=1010000 addr=40 wd=0 be=0 pulses=0",
                     ctl, mc_addr_out, mc_write_data_out, mc_write_byte_en_out, pulses);
        end
        tick();
        mc_ready_in = 1'b1;
        #1;
        n_cmp++;
        if (pulses !== 6'b100000 || mc_valid_out !== 1'b1) begin
            n_bad++; $display("FAIL ifu_ready: got pulses=%b valid=%b required 100000 1", pulses, mc_valid_out);
        end
        tick();
        mc_ready_in = 1'b0; ifu_valid_in = 1'b0;
        #1;
        n_cmp++;
        if (mc_valid_out !== 1'b0 || pulses !== 6'b0) begin
            n_bad++; $display("FAIL ifu_resp_wait: got valid=%b pulses=%b required 0 0", mc_valid_out, pulses);
        end
        tick();
        mc_rdata_valid_in = 1'b1; mc_read_data_in = 32'hDEAD_BEEF;
        tick();
        mc_rdata_valid_in = 1'b0; mc_read_data_in = '0;
        #1;
        n_cmp++;
        if (pulses !== 6'b010000 || rdata_out !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL ifu_rdata: got pulses=%b rdata=%h required 010000 deadbeef", pulses, rdata_out);
        end
        tick();
        #1;
        n_cmp++;
        if (pulses !== 6'b0 || rdata_out !== 32'hDEAD_BEEF || mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL ifu_after: got pulses=%b rdata=%h valid=%b required 0 deadbeef 0", pulses, rdata_out, mc_valid_out);
        end
    endtask

    task automatic test_lsu_write();
        lsu_valid_in = 1'b1; lsu_addr_in = 32'h1000_0008; lsu_write_en_in = 1'b1;
        lsu_write_data_in = 32'h1234_5678; lsu_write_byte_en_in = 4'b0011;
        tick();
        mc_ready_in = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 7'b1101011 || mc_write_byte_en_out !== 4'b0011 || mc_addr_out !== 32'h1000_0008
            || mc_write_data_out !== 32'h1234_5678 || pulses !== 6'b000100) begin
            n_bad++;
            $display("FAIL lsu_wr_req: got ctl=%b be=%b addr=%h wd=%h pulses=%b required 1101011 0011 10000008 12345678 000100",
                     ctl, mc_write_byte_en_out, mc_addr_out, mc_write_data_out, pulses);
        end
        tick();
        mc_ready_in = 1'b0; lsu_valid_in = 1'b0;
        #1;
        n_cmp++;
        if (pulses !== 6'b000010 || mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL lsu_wr_done: got pulses=%b valid=%b required 000010 0", pulses, mc_valid_out);
        end
        tick();
        #1;
        n_cmp++;
        if (pulses !== 6'b0 || rdata_out !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL lsu_wr_after: got pulses=%b rdata=%h required 0 deadbeef", pulses, rdata_out);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_lsu;
        logic [31:0] dat;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ifu_valid_in = 1'b1; ifu_addr_in = 32'h0000_0100;
        lsu_valid_in = 1'b1; lsu_addr_in = 32'h1000_0200; lsu_write_en_in = 1'b0;
        lsu_write_data_in = 32'hCAFE_F00D; lsu_write_byte_en_in = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2 == 1);
            dat = 32'h1111_0000 + 32'(i);
            mc_ready_in = 1'b1;
            #1;
            n_cmp++;
            if (exp_lsu ? (mc_addr_out !== 32'h1000_0200 || ctl !== 7'b1110111 || mc_write_data_out !== 32'hCAFE_F00D
                           || pulses !== 6'b000100)
                        : (mc_addr_out !== 32'h0000_0100 || ctl !== 7'b1010000 || mc_write_data_out !== 32'h0
                           || pulses !== 6'b100000)) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got addr=%h ctl=%b wd=%h pulses=%b required owner %s",
                         i, mc_addr_out, ctl, mc_write_data_out, pulses, exp_lsu ? "LSU" : "IFU");
            end
            tick();
            mc_ready_in = 1'b0; mc_rdata_valid_in = 1'b1; mc_read_data_in = dat;
            tick();
            mc_rdata_valid_in = 1'b0; mc_read_data_in = '0;
            if (i == 3) begin
                ifu_valid_in = 1'b0; lsu_valid_in = 1'b0;
            end
            #1;
            n_cmp++;
            if (pulses !== (exp_lsu ? 6'b000010 : 6'b010000) || rdata_out !== dat) begin
                n_bad++;
                $display("FAIL rr_rdata%0d: got pulses=%b rdata=%h required %b %h",
                         i, pulses, rdata_out, exp_lsu ? 6'b000010 : 6'b010000, dat);
            end
            tick();
            #1;
            n_cmp++;
            if (mc_valid_out !== 1'b0 || pulses !== 6'b0) begin
                n_bad++; $display("FAIL rr_gap%0d: got valid=%b pulses=%b required 0 0", i, mc_valid_out, pulses);
            end
            tick();
        end
    endtask

    task automatic test_lsu_fast_read();
        lsu_valid_in = 1'b1; lsu_addr_in = 32'h2000_0000; lsu_write_en_in = 1'b0;
        lsu_write_data_in = '0; lsu_write_byte_en_in = 4'hF;
        #1;
        n_cmp++;
        if (mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL fast_idle: got valid=%b required 0", mc_valid_out);
        end
        tick();
        mc_ready_in = 1'b1; mc_rdata_valid_in = 1'b1; mc_read_data_in = 32'hA5A5_A5A5;
        #1;
        n_cmp++;
        if (ctl !== 7'b1010111 || mc_addr_out !== 32'h2000_0000 || pulses !== 6'b000100) begin
            n_bad++; $display("FAIL fast_req: got ctl=%b addr=%h pulses=%b required 1010111 20000000 000100", ctl, mc_addr_out, pulses);
        end
        tick();
        mc_ready_in = 1'b0; mc_rdata_valid_in = 1'b0; mc_read_data_in = '0; lsu_valid_in = 1'b0;
        #1;
        n_cmp++;
        if (pulses !== 6'b000010 || rdata_out !== 32'hA5A5_A5A5 || mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL fast_rdata: got pulses=%b rdata=%h valid=%b required 000010 a5a5a5a5 0", pulses, rdata_out, mc_valid_out);
        end
        tick();
        #1;
        n_cmp++;
        if (pulses !== 6'b0 || mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL fast_after: got pulses=%b valid=%b required 0 0", pulses, mc_valid_out);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        ifu_valid_in = 1'b1; ifu_addr_in = 32'h0000_0080;
        tick();
        mc_ready_in = 1'b1;
        #1;
        n_cmp++;
        if (pulses !== 6'b100000) begin
            n_bad++; $display("FAIL to_ready: got pulses=%b required 100000", pulses);
        end
        tick();
        mc_ready_in = 1'b0; ifu_valid_in = 1'b0;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            #1;
            if (pulses !== 6'b0 || mc_valid_out !== 1'b0) early++;
            tick();
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++; $display("FAIL to_early: got %0d cycles with pulses/valid required 0", early);
        end
        mc_rdata_valid_in = 1'b1; mc_read_data_in = 32'hBAD0_BAD0;
        #1;
        n_cmp++;
        if (pulses !== 6'b001000 || rdata_out !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL to_err: got pulses=%b rdata=%h required 001000 a5a5a5a5", pulses, rdata_out);
        end
        tick();
        mc_rdata_valid_in = 1'b0; mc_read_data_in = '0;
        tick();
        #1;
        n_cmp++;
        if (pulses !== 6'b0 || rdata_out !== 32'hA5A5_A5A5 || mc_valid_out !== 1'b0) begin
            n_bad++; $display("FAIL to_late_drop: got pulses=%b rdata=%h valid=%b required 0 a5a5a5a5 0", pulses, rdata_out, mc_valid_out);
        end
    endtask

    task automatic test_reset_mid();
        lsu_valid_in = 1'b1; lsu_addr_in = 32'h1000_0010; lsu_write_en_in = 1'b1;
        lsu_write_data_in = 32'h0BAD_F00D; lsu_write_byte_en_in = 4'hF;
        tick();
        #1;
        n_cmp++;
        if (mc_valid_out !== 1'b1 || mc_write_en_out !== 1'b1) begin
            n_bad++; $display("FAIL mid_req: got valid=%b wr=%b required 1 1", mc_valid_out, mc_write_en_out);
        end
        rst = 1'b0;
        ifu_valid_in = 1'b1; ifu_addr_in = 32'h0000_0200;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got %h required 0", all_out);
        end
        tick();
        #1;
        n_cmp++;
        if (mc_valid_out !== 1'b1 || mc_addr_out !== 32'h0000_0200 || mc_cs_out !== 1'b0 || pulses !== 6'b0) begin
            n_bad++; $display("FAIL mid_tie_ifu: got valid=%b addr=%h cs=%b pulses=%b required 1 00000200 0 0",
                              mc_valid_out, mc_addr_out, mc_cs_out, pulses);
        end
        ifu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        mc_ready_in = 1'b1; mc_rdata_valid_in = 1'b1; mc_read_data_in = 32'h7777_7777;
        tick();
        mc_ready_in = 1'b0; mc_rdata_valid_in = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_round_robin();
        test_lsu_fast_read();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory controller port between the instruction-fetch requester (IFU) and the load/store requester (LSU). It arbitrates round-robin and holds a grant until the transaction completes, with one transaction outstanding at a time. It drives the memory controller's valid/ready/rdata_valid handshake and generates the instr/data region select (cs). A watchdog terminates any transaction that the memory controller never completes.

Parameters:
DATA_REGION, 4'h1, value of addr[31:28] that selects data RAM (cs=1) for LSU accesses
TIMEOUT, 64, cycles allowed in REQ or RESP state before an error completion (must be >=2)
TW, 7, width of the watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
ifu_valid_in  in  1  IFU read request
ifu_addr_in  in  32  IFU fetch address
ifu_ready_out  out  1  IFU request accepted (1-cycle pulse)
ifu_rdata_valid_out  out  1  IFU read data valid (1-cycle pulse)
ifu_err_out  out  1  IFU transaction timed out (1-cycle pulse)
lsu_valid_in  in  1  LSU request
lsu_addr_in  in  32  LSU address
lsu_write_en_in  in  1  1=write, 0=read
lsu_write_data_in  in  32  LSU write data
lsu_write_byte_en_in  in  4  LSU byte enables
lsu_ready_out  out  1  LSU request accepted (1-cycle pulse)
lsu_rdata_valid_out  out  1  LSU read data valid / write done (1-cycle pulse)
lsu_err_out  out  1  LSU transaction timed out (1-cycle pulse)
rdata_out  out  32  read data returned to the owner of the current rdata_valid pulse
mc_addr_out  out  32  address to mem controller
mc_write_data_out  out  32  write data
mc_write_byte_en_out  out  4  byte enables
mc_cs_out  out  1  1=data RAM, 0=instr RAM
mc_read_en_out  out  1  read strobe
mc_write_en_out  out  1  write strobe
mc_valid_out  out  1  request valid
mc_ready_in  in  1  mem controller accepted
mc_rdata_valid_in  in  1  mem controller read data valid
mc_read_data_in  in  32  mem controller read data

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, last_grant=LSU (so IFU wins first tie), watchdog=0. All outputs are 0, including all mc_* buses and rdata_out.
- States: IDLE, REQ, RESP.
- IDLE: if any valid_in is high, pick the owner, register the owner's request into the mc_* registers, and go to REQ next cycle. Request-to-mc_valid latency is 1 cycle.
- Arbitration: if only one requester is valid, it wins. If both are valid, the requester other than last_grant wins. last_grant updates on the grant.
- IFU request fields: cs=0, read_en=1, write_en=0, byte_en=0, write_data=0.
- LSU request fields: cs=(addr[31:28]==DATA_REGION); read_en=!write_en_in; write_en=write_en_in.
- REQ: mc_valid_out=1; the mc_* fields are held stable. On mc_ready_in: pulse the owner's ready_out in the same cycle (combinational from mc_ready_in & state==REQ) and drop mc_valid_out next cycle.
  - Read: go to RESP.
  - Write: pulse lsu_rdata_valid_out the next cycle and return to IDLE.
- RESP: on mc_rdata_valid_in, register mc_read_data_in into rdata_out, pulse the owner's rdata_valid_out 1 cycle later, then go to IDLE. rdata_out holds its value until the next response.
- mc_ready_in and mc_rdata_valid_in in the same REQ cycle: accept both; complete directly as a response and go to IDLE (skip RESP).
- Back-to-back: the earliest re-arbitration is the cycle after the completion pulse. Minimum read occupancy is 3 cycles.
- Requesters must hold valid_in and their fields until ready_out. The arbiter ignores changes once a grant is given.
- Watchdog: counts cycles in REQ/RESP and clears on a state change. At TIMEOUT it pulses the owner's err_out (no rdata_valid), deasserts mc_valid_out, and goes to IDLE. A late mc_rdata_valid_in arriving in IDLE is dropped.
- mc_rdata_valid_in in IDLE/REQ without an outstanding read is ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No completion pulse is issued.

Decomposition:
- Shared package mem_pkg:
  - state encoding (ST_IDLE=2'd0, ST_REQ=2'd1, ST_RESP=2'd2)
  - requester IDs (REQ_IFU=1'b0, REQ_LSU=1'b1)
  - DATA_REGION default constant
- One natural sub-module: rr_arbiter2 (combinational two-input round-robin pick plus registered last_grant).
- The FSM and watchdog stay in mem_arbiter.

Test Plan:
- IFU only: ifu_valid, addr=0x0000_0040; mc_ready 1 cycle after mc_valid; rdata_valid+0xDEADBEEF 2 cycles later -> mc_cs_out=0, ifu_ready pulse, ifu_rdata_valid pulse with rdata_out=0xDEADBEEF, back to IDLE.
- LSU write to 0x1000_0008, data 0x12345678, byte_en 4'b0011 -> mc_cs_out=1, write_en=1, read_en=0, byte_en=0011; lsu_rdata_valid pulse 1 cycle after mc_ready; no RESP state.
- Both valid continuously for 4 transactions after reset -> grant order IFU, LSU, IFU, LSU; each requester's mc_* fields are correct and there is no rdata crossover.
- LSU read 0x2000_0000 -> mc_cs_out=0 (region mismatch); same-cycle mc_ready+mc_rdata_valid=0xA5A5A5A5 -> lsu_ready and then lsu_rdata_valid with 0xA5A5A5A5, no RESP state.
- IFU read, mc_ready given, mc_rdata_valid never arrives -> ifu_err pulse exactly TIMEOUT cycles after entering RESP, then IDLE; a subsequent late mc_rdata_valid is ignored.
- rst=0 asserted while in REQ with mc_valid_out=1 -> next cycle all outputs 0, state IDLE; after release, IFU is granted first on a tie.
